// File: rtl/prio_enc_pkg.sv
// Shared types for the registered priority encoder: arbitration mode and handshake FSM states.
package prio_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } prio_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } prio_state_e;

endpackage

// File: rtl/prio_encoder_seq_pick.sv
// Combinational N-wide priority picker: returns the highest or lowest set bit of an
// active-high request vector together with a found flag.
module prio_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic         pick_high,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (pick_high) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) begin
          idx   = W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req[N-1-i]) begin
          idx   = W'(N-1-i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered N-to-log2(N) priority encoder with active-low requests, fixed or round-robin
// arbitration and a valid/ready output. Define PRIO_ENC_CASCADE_EN for 74148-style cascade pins.
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_n,
  input  logic         mode,
  input  logic         out_ready,
`ifdef PRIO_ENC_CASCADE_EN
  input  logic         ei_n,
  output logic         eo_n,
  output logic         gs_n,
`endif
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         any_req
);

  prio_state_e  state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [W-1:0] ptr_q, ptr_d;

  prio_mode_e   mode_e;
  logic [N-1:0] req;
  logic [N-1:0] req_masked;
  logic [W-1:0] fix_idx, rrm_idx, rrf_idx, pick;
  logic         fix_found, rrm_found, full_found_unused;
  logic         grant_en;

  assign mode_e = prio_mode_e'(mode);
  assign req    = ~req_n;

  prio_pick #(.N(N), .W(W)) u_pick_fixed (
    .req       (req),
    .pick_high (1'b1),
    .idx       (fix_idx),
    .found     (fix_found)
  );

  prio_pick #(.N(N), .W(W)) u_pick_rr_masked (
    .req       (req_masked),
    .pick_high (1'b0),
    .idx       (rrm_idx),
    .found     (rrm_found)
  );

  prio_pick #(.N(N), .W(W)) u_pick_rr_full (
    .req       (req),
    .pick_high (1'b0),
    .idx       (rrf_idx),
    .found     (full_found_unused)
  );

  assign any_req = fix_found;

`ifdef PRIO_ENC_CASCADE_EN
  assign grant_en = any_req & ~ei_n;
  assign eo_n     = ~(~ei_n & ~any_req);
  assign gs_n     = ~out_valid_q;
`else
  assign grant_en = any_req;
`endif

  // The round-robin mask uses the pointer as it will be after this edge's acceptance,
  // so back-to-back acceptances advance past the index just consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (mode_e == MODE_RR && out_valid_q && out_ready) begin
      ptr_d = (out_idx_q == W'(N-1)) ? '0 : out_idx_q + W'(1);
    end
  end

  always_comb begin
    req_masked = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_masked[i] = req[i] && (W'(i) >= ptr_d);
    end
  end

  always_comb begin
    if (mode_e == MODE_RR) begin
      pick = rrm_found ? rrm_idx : rrf_idx;
    end else begin
      pick = fix_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (state_q == ST_IDLE || out_ready) begin
      if (grant_en) begin
        out_idx_d   = pick;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end else begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Directed bench for prio_encoder_seq: table of fixed-priority vectors plus hand-written
// round-robin, handshake, N=5 and reset sequences.
module tb_prio_encoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_n8;
  logic       mode8, ready8;
  logic       valid8, any8;
  logic [2:0] idx8;
  logic [4:0] req_n5;
  logic       mode5, ready5;
  logic       valid5, any5;
  logic [2:0] idx5;
`ifdef PRIO_ENC_CASCADE_EN
  logic       ei_n8, eo_n8, gs_n8;
  logic       ei_n5, eo_n5, gs_n5;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  prio_encoder_seq #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n8),
    .mode      (mode8),
    .out_ready (ready8),
`ifdef PRIO_ENC_CASCADE_EN
    .ei_n      (ei_n8),
    .eo_n      (eo_n8),
    .gs_n      (gs_n8),
`endif
    .out_valid (valid8),
    .out_idx   (idx8),
    .any_req   (any8)
  );

  prio_encoder_seq #(.N(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n5),
    .mode      (mode5),
    .out_ready (ready5),
`ifdef PRIO_ENC_CASCADE_EN
    .ei_n      (ei_n5),
    .eo_n      (eo_n5),
    .gs_n      (gs_n5),
`endif
    .out_valid (valid5),
    .out_idx   (idx5),
    .any_req   (any5)
  );

  typedef struct {
    logic [7:0] req_n;
    logic       mode;
    logic [2:0] exp_idx;
    logic       exp_valid;
    logic       exp_any;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input int unsigned e_idx, input int unsigned e_valid);
    check({name, " idx"}, idx8, e_idx);
    check({name, " valid"}, valid8, e_valid);
  endtask

  initial begin
    int unsigned rr_exp[5];
    rr_exp = '{0, 3, 5, 6, 0};

    vecs[0]  = '{8'b11111110, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[1]  = '{8'b11111101, 1'b0, 3'd1, 1'b1, 1'b1};
    vecs[2]  = '{8'b11111011, 1'b0, 3'd2, 1'b1, 1'b1};
    vecs[3]  = '{8'b11110111, 1'b0, 3'd3, 1'b1, 1'b1};
    vecs[4]  = '{8'b11101111, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[5]  = '{8'b11011111, 1'b0, 3'd5, 1'b1, 1'b1};
    vecs[6]  = '{8'b10111111, 1'b0, 3'd6, 1'b1, 1'b1};
    vecs[7]  = '{8'b01111111, 1'b0, 3'd7, 1'b1, 1'b1};
    vecs[8]  = '{8'b01010101, 1'b0, 3'd7, 1'b1, 1'b1};
    vecs[9]  = '{8'b11010101, 1'b0, 3'd5, 1'b1, 1'b1};
    vecs[10] = '{8'b11111111, 1'b0, 3'd5, 1'b0, 1'b0};
    vecs[11] = '{8'b00000000, 1'b0, 3'd7, 1'b1, 1'b1};

    rst = 1'b1;
    req_n8 = '1; mode8 = 1'b0; ready8 = 1'b1;
    req_n5 = '1; mode5 = 1'b0; ready5 = 1'b1;
`ifdef PRIO_ENC_CASCADE_EN
    ei_n8 = 1'b0; ei_n5 = 1'b0;
`endif
    tick();
    tick();
    check8("reset", 0, 0);
    check("reset any_req", any8, 0);
    check("reset5 valid", valid5, 0);
    check("reset5 idx", idx5, 0);

    // Fixed priority, back-to-back with out_ready held high
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_n8 = vecs[i].req_n;
      mode8  = vecs[i].mode;
      tick();
      check8($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_valid);
      check($sformatf("vec%0d any_req", i), any8, vecs[i].exp_any);
    end

    // Round-robin from a fresh pointer, requests at 0,3,5,6
    rst = 1'b1; req_n8 = '1; tick();
    rst = 1'b0; mode8 = 1'b1; ready8 = 1'b1; req_n8 = 8'b10010110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check8($sformatf("rr%0d", i), rr_exp[i], 1);
    end

    // Handshake hold: result frozen while out_ready is low
    rst = 1'b1; tick();
    rst = 1'b0; mode8 = 1'b0; ready8 = 1'b0; req_n8 = 8'b11101111;
    tick();
    check8("hold load", 4, 1);
    req_n8 = 8'b11111101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check8($sformatf("hold%0d", i), 4, 1);
    end
    ready8 = 1'b1;
    tick();
    check8("hold release", 1, 1);

    // Non-power-of-two width, pointer wraps at N-1
    mode5 = 1'b1; ready5 = 1'b1; req_n5 = 5'b01110;
    tick();
    check("n5 pick0 idx", idx5, 0);
    check("n5 pick0 valid", valid5, 1);
    tick();
    check("n5 pick1 idx", idx5, 4);
    tick();
    check("n5 wrap idx", idx5, 0);
    check("n5 wrap valid", valid5, 1);

    // Reset mid-HOLD with out_ready high; pointer must return to 0
    rst = 1'b1; tick();
    rst = 1'b0; mode8 = 1'b1; ready8 = 1'b1; req_n8 = 8'b10010110;
    tick();
    tick();
    check8("pre-reset", 3, 1);
    rst = 1'b1;
    tick();
    check8("mid-hold reset", 0, 0);
    rst = 1'b0;
    tick();
    check8("post-reset ptr", 0, 1);

`ifdef PRIO_ENC_CASCADE_EN
    rst = 1'b1; tick();
    rst = 1'b0; mode8 = 1'b0; ei_n8 = 1'b1; req_n8 = 8'b11101111;
    tick();
    check("cascade disabled valid", valid8, 0);
    check("cascade disabled eo_n", eo_n8, 1);
    check("cascade disabled gs_n", gs_n8, 1);
    ei_n8 = 1'b0;
    tick();
    check("cascade enabled idx", idx8, 4);
    check("cascade enabled gs_n", gs_n8, 0);
    check("cascade enabled eo_n", eo_n8, 1);
    req_n8 = '1;
    #1;
    check("cascade idle eo_n", eo_n8, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
